// File: rtl/myproject_mul_pipe.sv
// myproject_mul_pipe: pipelined multiplier with per-operand signedness,
// fixed-point right shift and optional saturation (MYPROJECT_MUL_PIPE_SAT_EN).
// Ports: ap_clk/ap_rst (sync, active-high), in_valid/in_ready + din0/din1,
//        out_valid/out_ready + dout/sat_flag. Global-stall valid/ready.
module myproject_mul_pipe #(
  parameter int DIN0_WIDTH  = 14,
  parameter int DIN1_WIDTH  = 12,
  parameter int DOUT_WIDTH  = 26,
  parameter int DIN0_SIGNED = 0,
  parameter int DIN1_SIGNED = 0,
  parameter int NUM_STAGE   = 2,
  parameter int SHIFT       = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  sat_flag
);

  localparam int P = DIN0_WIDTH + DIN1_WIDTH;
  localparam bit RS = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);

  logic                 adv;
  logic                 acc;
  logic [NUM_STAGE-1:0] v;

  assign out_valid = v[NUM_STAGE-1];
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv & ~ap_rst;
  assign acc       = in_valid & in_ready;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      v <= '0;
    end else if (adv) begin
      v[0] <= acc;
      for (int i = 1; i < NUM_STAGE; i++)
        v[i] <= v[i-1];
    end
  end

  logic [DIN0_WIDTH-1:0] ma;
  logic [DIN1_WIDTH-1:0] mb;

  // With a single stage the multiplier feeds the output register directly.
  generate
    if (NUM_STAGE == 1) begin : g_opdirect
      assign ma = din0;
      assign mb = din1;
    end else begin : g_opreg
      always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
          ma <= '0;
          mb <= '0;
        end else if (adv) begin
          ma <= din0;
          mb <= din1;
        end
      end
    end
  endgenerate

  logic signed [DIN0_WIDTH:0] ax;
  logic signed [DIN1_WIDTH:0] bx;
  logic signed [P-1:0]        ae;
  logic signed [P-1:0]        be;
  logic signed [P-1:0]        prod;

  assign ax = {(DIN0_SIGNED != 0) & ma[DIN0_WIDTH-1], ma};
  assign bx = {(DIN1_SIGNED != 0) & mb[DIN1_WIDTH-1], mb};
  assign ae = P'(ax);
  assign be = P'(bx);
  // The exact product of the extended operands always fits in P bits,
  // so a P-bit modular multiply is exact.
  assign prod = ae * be;

  logic signed [P-1:0] np;

  generate
    if (NUM_STAGE <= 2) begin : g_pdirect
      assign np = prod;
    end else begin : g_ppipe
      logic signed [P-1:0] pr [NUM_STAGE-2];
      always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
          for (int i = 0; i < NUM_STAGE-2; i++)
            pr[i] <= '0;
        end else if (adv) begin
          pr[0] <= prod;
          for (int i = 1; i < NUM_STAGE-2; i++)
            pr[i] <= pr[i-1];
        end
      end
      assign np = pr[NUM_STAGE-3];
    end
  endgenerate

  logic [DOUT_WIDTH-1:0] nd;

`ifdef MYPROJECT_MUL_PIPE_SAT_EN
  localparam int XW = ((P > DOUT_WIDTH) ? P : DOUT_WIDTH) + 2;
  localparam logic signed [XW-1:0] HI = RS ?
    ((XW'(1) <<< (DOUT_WIDTH-1)) - XW'(1)) :
    ((XW'(1) <<< DOUT_WIDTH) - XW'(1));
  localparam logic signed [XW-1:0] LO = RS ?
    -(XW'(1) <<< (DOUT_WIDTH-1)) : XW'(0);

  logic signed [XW-1:0] xs;
  logic                 nf;

  // xs carries the shifted product with headroom so that the
  // range comparisons see the true value.
  always_comb begin
    if (RS) xs = XW'(np >>> SHIFT);
    else    xs = XW'($unsigned(np) >> SHIFT);
    nd = xs[DOUT_WIDTH-1:0];
    nf = 1'b0;
    if (xs > HI) begin
      nd = HI[DOUT_WIDTH-1:0];
      nf = 1'b1;
    end else if (xs < LO) begin
      nd = LO[DOUT_WIDTH-1:0];
      nf = 1'b1;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) sat_flag <= 1'b0;
    else if (adv) sat_flag <= nf;
  end
`else
  always_comb begin
    if (RS) nd = DOUT_WIDTH'(np >>> SHIFT);
    else    nd = DOUT_WIDTH'($unsigned(np) >> SHIFT);
  end

  assign sat_flag = 1'b0;
`endif

  always_ff @(posedge ap_clk) begin
    if (ap_rst) dout <= '0;
    else if (adv) dout <= nd;
  end

endmodule
